reg_file_param: RTL

//  - Parametrised register file: 2**ADDR_W registers of WIDTH bits, two registered read ports, one write port.
//  - Successor to the fixed 32-bit register and 5x32 decoder pair.
//  - Sits between the control unit and the ALU datapath.
//  - Adds options the fixed parts lack: hard-wired zero register and write-to-read bypass.
//  - Defines behaviour when read and write occur in the same cycle.

---
 rtl/reg_file_param.sv | 74 +++++++
 1 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: 2**ADDR_W x WIDTH, one write port and two registered read ports.
// All state changes on the falling clock edge; asynchronous active-low reset clears everything.
module reg_file_param #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr_r1,
    input  logic [ADDR_W-1:0] addr_r2,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic [WIDTH-1:0]  data_w,
    output logic [WIDTH-1:0]  data_r1,
    output logic [WIDTH-1:0]  data_r2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]  we;
    logic [ADDR_W-1:0] addr_wr;
    logic [WIDTH-1:0]  rd1_next;
    logic [WIDTH-1:0]  rd2_next;

    // Internal alias keeps the write-address port distinct from the ADDR_W parameter.
    assign addr_wr = addr_w;

    // One enable per register, so an unknown write strobe can only reach the addressed entry.
    always_comb begin
        we = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!(ZERO_REG && i == 0)) begin
                we[i] = write && (addr_wr == ADDR_W'(i));
            end
        end
    end

    always_comb begin
        rd1_next = mem[addr_r1];
        rd2_next = mem[addr_r2];
        if (BYPASS && write && addr_r1 == addr_wr) rd1_next = data_w;
        if (BYPASS && write && addr_r2 == addr_wr) rd2_next = data_w;
        if (ZERO_REG && addr_r1 == '0) rd1_next = '0;
        if (ZERO_REG && addr_r2 == '0) rd2_next = '0;
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we[i]) mem[i] <= data_w;
            end
        end
    end

    // Read registers hold their value while read is low, regardless of later writes.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            data_r1 <= '0;
            data_r2 <= '0;
        end else if (read) begin
            data_r1 <= rd1_next;
            data_r2 <= rd2_next;
        end
    end

endmodule
